regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port integer register file with write-through bypass, hardwired zero register and a per-register pending-write scoreboard. Sits between decode/issue and writeback in the RV32 core. It replaces the fixed 32x32 two-read-port file and lets issue logic detect RAW hazards without a separate hazard table.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_REGS, 32, register count; power of two, at least 2
- NUM_RD, 2, number of read ports, 1 to 4
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy
- AW, $clog2(NUM_REGS), derived address width; not overridable

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-low reset, sampled on rising clk edge
- rd_addr  in  NUM_RD*AW  read addresses; port k occupies bits [k*AW +: AW]
- rd_data  out  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k's register has a pending write not satisfied this cycle
- w_en  in  1  writeback enable
- w_addr  in  AW  writeback address
- w_data  in  DATA_W  writeback data
- iss_en  in  1  issue of an instruction that will write iss_addr
- iss_addr  in  AW  destination of issued instruction
- busy_vec  out  NUM_REGS  registered scoreboard state, bit i = register i pending

## Operation
- Storage: NUM_REGS x DATA_W flops. On clk with reset high and w_en=1: reg[w_addr] <= w_data, except when ZERO_REG=1 and w_addr=0.
- Reads are combinational per port k, in priority order:
  - ZERO_REG=1 and rd_addr_k=0 -> 0.
  - w_en=1 and w_addr=rd_addr_k -> w_data (same-cycle bypass).
  - otherwise reg[rd_addr_k].
- Scoreboard busy[i], one flop per register:
  - iss_en=1 sets busy[iss_addr].
  - w_en=1 clears busy[w_addr].
  - Same address, same cycle: set wins, so busy stays 1 because the newer producer is still outstanding.
  - Different addresses: both actions apply.
  - ZERO_REG=1: busy[0] is constant 0; issue to register 0 is ignored.
- rd_busy_k = busy[rd_addr_k] AND NOT (w_en AND w_addr=rd_addr_k). A bypassed writeback satisfies the read even if a same-cycle issue re-sets the bit.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- Issue to an already-busy register is legal: busy stays 1. There is no counting; the file tracks only the newest producer.
- Any number of read ports may read the same address; all return identical data.

## Timing
- Read latency is 0 cycles (combinational from rd_addr, w_en, w_addr, w_data). A written value appears from storage on the cycle after the write edge, and via bypass in the write cycle itself.
- Scoreboard latency is 1 cycle: busy_vec reflects iss_en and w_en from the previous edge.
- Reset (reset=0 at an edge):
  - All registers go to 0 and all busy bits to 0.
  - w_en and iss_en are ignored that cycle.
  - Outputs after the reset edge: rd_data=0, rd_busy=0, busy_vec=0.
  - Reset mid-operation discards all pending-write state; the core must flush in the same cycle.
- While reset=0, rd_data still follows the combinational bypass path. Consumers must ignore it.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.

## Structure
- Package regfile_pkg holds:
  - default constants RF_DATA_W=32, RF_NUM_REGS=32, RF_NUM_RD=2;
  - a function addr_w(n) returning $clog2(n).
- Sub-module regfile_scoreboard (parameters NUM_REGS, ZERO_REG) holds:
  - the busy flops with set/clear priority;
  - busy_vec output;
  - a combinational lookup used per read port.
- The top level builds the storage array and NUM_RD read/bypass muxes with a generate loop.

## Test plan
- Reset: write reg 5 = 0xDEADBEEF, then hold reset=0 for one edge -> rd_data for addr 5 = 0, busy_vec=0.
- Write/read with bypass: w_en=1, w_addr=3, w_data=0x12345678, rd_addr port0=3 in the same cycle -> port0 = 0x12345678 in that cycle and after the edge.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to reg 0 and issue to reg 0 -> reads 0 and busy_vec[0]=0 on all ports.
- Scoreboard, basic: iss_en to reg 7 -> busy_vec[7]=1 next cycle and rd_busy=1 for port reading 7. Then writeback 7 -> rd_busy=0 in the writeback cycle, busy_vec[7]=0 next cycle.
- Scoreboard, collision: with reg 9 busy, issue 9 and writeback 9 with 0xA5 in the same cycle -> rd_data=0xA5, rd_busy=0 that cycle, busy_vec[9]=1 afterwards.
- Multi-port (NUM_RD=4, NUM_REGS=64): random writes to regs 1..63, all four ports reading distinct and identical addresses -> every port matches the reference model each cycle.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 32;
    localparam int RF_NUM_RD   = 2;

    // Address width needed to select one of n registers.
    function automatic int addr_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus between issue/writeback logic (master) and the register file (slave).
interface regfile_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD
) ();

    localparam int AW = addr_w(NUM_REGS);

    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     w_en;
    logic [AW-1:0]            w_addr;
    logic [DATA_W-1:0]        w_data;
    logic                     iss_en;
    logic [AW-1:0]            iss_addr;
    logic [NUM_REGS-1:0]      busy_vec;

    modport master (
        output rd_addr, w_en, w_addr, w_data, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_vec
    );

    modport slave (
        input  rd_addr, w_en, w_addr, w_data, iss_en, iss_addr,
        output rd_data, rd_busy, busy_vec
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write tracker. Issue sets a bit, writeback clears it;
// when both hit the same register in one cycle the issue wins because the
// newer producer is still outstanding.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int ZERO_REG = 1,
    parameter int NUM_RD   = RF_NUM_RD,
    localparam int AW      = addr_w(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic                 w_en,
    input  logic [AW-1:0]        w_addr,
    input  logic [NUM_RD*AW-1:0] lk_addr,
    output logic [NUM_RD-1:0]    lk_busy,
    output logic [NUM_REGS-1:0]  busy_vec
);

    logic [NUM_REGS-1:0] busy_reg;
    logic [NUM_REGS-1:0] busy_next;

    // Next scoreboard state: clear on writeback first, then let issue override.
    always_comb begin
        busy_next = busy_reg;
        if (w_en) begin
            busy_next[w_addr] = 1'b0;
        end
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            busy_next[0] = 1'b0;
        end
    end

    // Scoreboard register; reset drops all outstanding producers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_reg <= '0;
        end else begin
            busy_reg <= busy_next;
        end
    end

    // Per-port lookup: a same-cycle writeback to the read address satisfies the
    // read even if an issue to that register lands in the same cycle.
    always_comb begin
        lk_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            lk_busy[k] = busy_reg[lk_addr[k*AW +: AW]]
                         && !(w_en && (w_addr == lk_addr[k*AW +: AW]));
        end
    end

    assign busy_vec = busy_reg;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write-through bypass, optional hardwired
// zero register and a pending-write scoreboard for RAW hazard detection.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int NUM_REGS = RF_NUM_REGS,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic         clk,
    input  logic         reset,
    regfile_mp_if.slave  bus
);

    localparam int AW = addr_w(NUM_REGS);

    logic [DATA_W-1:0]        mem_reg [NUM_REGS];
    logic [DATA_W-1:0]        rd_word [NUM_RD];
    logic [NUM_RD*DATA_W-1:0] rd_flat;
    logic                     zero_write;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign zero_write = (ZERO_REG != 0) && (bus.w_addr == '0);

    // Storage array; reset clears every register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (bus.w_en && !zero_write) begin
            mem_reg[bus.w_addr] <= bus.w_data;
        end
    end

    // One read mux per port: zero register, then same-cycle bypass, then storage.
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : gen_rd
        logic [AW-1:0] addr;
        assign addr = bus.rd_addr[gi*AW +: AW];
        assign rd_word[gi] = ((ZERO_REG != 0) && (addr == '0)) ? '0
                           : (bus.w_en && (bus.w_addr == addr)) ? bus.w_data
                           : mem_reg[addr];
    end

    // Pack per-port words onto the flat read-data bus.
    always_comb begin
        rd_flat = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rd_flat[k*DATA_W +: DATA_W] = rd_word[k];
        end
    end

    assign bus.rd_data = rd_flat;

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_REG (ZERO_REG),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .w_en     (bus.w_en),
        .w_addr   (bus.w_addr),
        .lk_addr  (bus.rd_addr),
        .lk_busy  (bus.rd_busy),
        .busy_vec (bus.busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: reset, bypass, zero register, scoreboard
// set/clear/collision and a four-port read sweep against a reference array.
module tb_regfile_mp;

    localparam int DW  = 32;
    localparam int NR  = 64;
    localparam int NRD = 4;
    localparam int AW  = 6;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    regfile_mp_if #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(NRD)) rf_if ();

    regfile_mp #(
        .DATA_W   (DW),
        .NUM_REGS (NR),
        .NUM_RD   (NRD),
        .ZERO_REG (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (rf_if)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [DW-1:0] model [NR];
    logic [AW-1:0] pa [NRD];
    logic [DW-1:0] exp_word;
    logic [AW-1:0] base;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok %s = 0x%0h", tag, got);
        end
    endtask

    function automatic logic [DW-1:0] port_data(input int k);
        return rf_if.rd_data[k*DW +: DW];
    endfunction

    task automatic set_addrs(input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                             input logic [AW-1:0] a2, input logic [AW-1:0] a3);
        rf_if.rd_addr = {a3, a2, a1, a0};
    endtask

    task automatic idle();
        rf_if.w_en     = 1'b0;
        rf_if.w_addr   = '0;
        rf_if.w_data   = '0;
        rf_if.iss_en   = 1'b0;
        rf_if.iss_addr = '0;
    endtask

    // Advance past one rising edge and settle just after the following falling edge.
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    initial begin
        idle();
        set_addrs(6'd5, 6'd6, 6'd7, 6'd8);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("reset_busy_vec", 64'(rf_if.busy_vec), 64'd0);
        check("reset_rd_busy", 64'(rf_if.rd_busy), 64'd0);
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("reset_data_p%0d", k), 64'(port_data(k)), 64'd0);
        end

        // Populate reg 5 and mark reg 6 busy, then reset and expect both gone.
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd5; rf_if.w_data = 32'hDEADBEEF;
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd6;
        tick();
        idle();
        #1;
        check("pre_rst_data5", 64'(port_data(0)), 64'hDEADBEEF);
        check("pre_rst_busy_vec", 64'(rf_if.busy_vec), 64'd1 << 6);
        check("pre_rst_rd_busy", 64'(rf_if.rd_busy), 64'b0010);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("post_rst_data5", 64'(port_data(0)), 64'd0);
        check("post_rst_busy_vec", 64'(rf_if.busy_vec), 64'd0);
        check("post_rst_rd_busy", 64'(rf_if.rd_busy), 64'd0);

        // Same-cycle bypass, then read back from storage.
        set_addrs(6'd3, 6'd0, 6'd0, 6'd0);
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd3; rf_if.w_data = 32'h12345678;
        #1;
        check("bypass_p0", 64'(port_data(0)), 64'h12345678);
        check("bypass_p1_zero", 64'(port_data(1)), 64'd0);
        tick();
        idle();
        #1;
        check("stored_p0", 64'(port_data(0)), 64'h12345678);

        // Zero register ignores writes and issues on every port.
        set_addrs(6'd0, 6'd0, 6'd0, 6'd0);
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd0; rf_if.w_data = 32'hFFFFFFFF;
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd0;
        #1;
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("zero_bypass_p%0d", k), 64'(port_data(k)), 64'd0);
        end
        check("zero_rd_busy", 64'(rf_if.rd_busy), 64'd0);
        tick();
        idle();
        #1;
        for (int k = 0; k < NRD; k++) begin
            check($sformatf("zero_stored_p%0d", k), 64'(port_data(k)), 64'd0);
        end
        check("zero_busy_vec", 64'(rf_if.busy_vec), 64'd0);

        // Basic scoreboard: issue 7, then writeback 7.
        set_addrs(6'd0, 6'd7, 6'd0, 6'd0);
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd7;
        #1;
        check("sb_issue_cycle_rd_busy", 64'(rf_if.rd_busy), 64'd0);
        tick();
        idle();
        #1;
        check("sb_busy_vec7", 64'(rf_if.busy_vec), 64'd1 << 7);
        check("sb_rd_busy7", 64'(rf_if.rd_busy), 64'b0010);
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd7; rf_if.w_data = 32'h77;
        #1;
        check("sb_wb_rd_busy", 64'(rf_if.rd_busy), 64'd0);
        check("sb_wb_data", 64'(port_data(1)), 64'h77);
        check("sb_wb_busy_vec_hold", 64'(rf_if.busy_vec), 64'd1 << 7);
        tick();
        idle();
        #1;
        check("sb_cleared_busy_vec", 64'(rf_if.busy_vec), 64'd0);
        check("sb_cleared_data", 64'(port_data(1)), 64'h77);

        // Collision: reg 9 busy, issue and writeback 9 together.
        set_addrs(6'd0, 6'd0, 6'd9, 6'd0);
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd9;
        tick();
        idle();
        #1;
        check("col_pre_busy_vec", 64'(rf_if.busy_vec), 64'd1 << 9);
        check("col_pre_rd_busy", 64'(rf_if.rd_busy), 64'b0100);
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd9;
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd9; rf_if.w_data = 32'hA5;
        #1;
        check("col_data", 64'(port_data(2)), 64'hA5);
        check("col_rd_busy", 64'(rf_if.rd_busy), 64'd0);
        tick();
        idle();
        #1;
        check("col_post_busy_vec", 64'(rf_if.busy_vec), 64'd1 << 9);
        check("col_post_rd_busy", 64'(rf_if.rd_busy), 64'b0100);
        check("col_post_data", 64'(port_data(2)), 64'hA5);

        // Different addresses in one cycle: issue 10 and retire 9.
        set_addrs(6'd0, 6'd10, 6'd9, 6'd0);
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd10;
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd9; rf_if.w_data = 32'hA6;
        #1;
        check("split_rd_busy", 64'(rf_if.rd_busy), 64'd0);
        tick();
        idle();
        #1;
        check("split_busy_vec", 64'(rf_if.busy_vec), 64'd1 << 10);
        check("split_rd_busy_after", 64'(rf_if.rd_busy), 64'b0010);
        check("split_data9", 64'(port_data(2)), 64'hA6);

        // Writeback to a non-busy register leaves the scoreboard alone.
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd11; rf_if.w_data = 32'hBB;
        tick();
        idle();
        #1;
        check("nonbusy_wb_busy_vec", 64'(rf_if.busy_vec), 64'd1 << 10);

        // Re-issue to a busy register keeps it busy; one writeback clears it.
        rf_if.iss_en = 1'b1; rf_if.iss_addr = 6'd10;
        tick();
        idle();
        #1;
        check("reissue_busy_vec", 64'(rf_if.busy_vec), 64'd1 << 10);
        rf_if.w_en = 1'b1; rf_if.w_addr = 6'd10; rf_if.w_data = 32'hCC;
        tick();
        idle();
        #1;
        check("reissue_cleared", 64'(rf_if.busy_vec), 64'd0);

        // Four-port sweep against a reference array, starting from reset.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < NR; i++) begin
            model[i] = '0;
        end
        for (int c = 0; c < 48; c++) begin
            rf_if.w_en   = ($urandom_range(0, 3) != 0);
            rf_if.w_addr = AW'($urandom_range(1, NR - 1));
            rf_if.w_data = $urandom;
            if (c % 2 == 0) begin
                base = AW'($urandom_range(0, NR - 1));
                for (int k = 0; k < NRD; k++) begin
                    pa[k] = base + AW'(k * 16);
                end
                pa[(c / 2) % NRD] = rf_if.w_addr;
            end else begin
                base = (c % 4 == 1) ? rf_if.w_addr : AW'($urandom_range(0, NR - 1));
                for (int k = 0; k < NRD; k++) begin
                    pa[k] = base;
                end
            end
            set_addrs(pa[0], pa[1], pa[2], pa[3]);
            #1;
            for (int k = 0; k < NRD; k++) begin
                if (pa[k] == '0) begin
                    exp_word = '0;
                end else if (rf_if.w_en && rf_if.w_addr == pa[k]) begin
                    exp_word = rf_if.w_data;
                end else begin
                    exp_word = model[pa[k]];
                end
                check($sformatf("mp_c%0d_p%0d_a%0d", c, k, pa[k]), 64'(port_data(k)), 64'(exp_word));
            end
            check($sformatf("mp_c%0d_rd_busy", c), 64'(rf_if.rd_busy), 64'd0);
            tick();
            if (rf_if.w_en) begin
                model[rf_if.w_addr] = rf_if.w_data;
            end
        end
        idle();
        #1;
        check("mp_final_busy_vec", 64'(rf_if.busy_vec), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
